// File: rtl/mem_unit.sv
// -----------------------------------------------------------------------------
// mem_unit -- memory-access stage of the datapath.
//
// Takes the EX/MEM pipeline register (control bits, ALU result, store data),
// performs a req/ack transaction on the data-memory bus with byte-lane
// steering and sub-word load extension, and writes the MEM/WB register.
// Upstream is stalled (in_ready=0) while a bus transaction is outstanding.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   defined   : a request that waits TIMEOUT_CYCLES cycles without mem_ack is
//               aborted with a one-cycle bus_err pulse.
//   undefined : requests wait for mem_ack indefinitely; bus_err is tied 0.
//
// Ports:
//   clock, reset          rising-edge clock, async active-low reset
//   in_valid / in_ready   EX/MEM handshake
//   MemWr_in, MemToReg_in, RegWr_in, Dsize_in, Loadext_in, rd_in,
//   alu_in, store_in      EX/MEM register contents
//   mem_req, mem_we, mem_addr, mem_be, mem_wdata   data-memory request
//   mem_ack, mem_rdata    data-memory response
//   wb_valid, wb_RegWr, wb_MemToReg, wb_rd, wb_data   MEM/WB register
//   misalign              pulse: misaligned access dropped
//   bus_err               pulse: request aborted by timeout
// -----------------------------------------------------------------------------
module mem_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        MemWr_in,
    input  logic        MemToReg_in,
    input  logic        RegWr_in,
    input  logic [1:0]  Dsize_in,
    input  logic        Loadext_in,
    input  logic [4:0]  rd_in,
    input  logic [31:0] alu_in,
    input  logic [31:0] store_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic        wb_RegWr,
    output logic        wb_MemToReg,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misalign,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state, state_nx;

    // Operation latched at acceptance, used when the bus transaction ends.
    logic        store_p0;
    logic        load_p0;
    logic        regwr_p0;
    logic [4:0]  rd_p0;
    logic [31:0] alu_p0;
    logic [1:0]  dsize_p0;
    logic        ext_p0;

    logic accept;
    logic is_mem;
    logic misal;
    logic start;
    logic ack_hit;
    logic timeout;

    // Byte enables for the addressed lane(s). Dsize 11 behaves as a word.
    function automatic logic [3:0] lane_be(input logic [1:0] dsize,
                                           input logic [1:0] off);
        logic [3:0] be;
        case (dsize)
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b0001 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Sub-word store data is replicated to every lane; mem_be picks the lane.
    function automatic logic [31:0] lane_wdata(input logic [1:0]  dsize,
                                               input logic [31:0] s);
        logic [31:0] w;
        case (dsize)
            2'b01:   w = {2{s[15:0]}};
            2'b10:   w = {4{s[7:0]}};
            default: w = s;
        endcase
        return w;
    endfunction

    // Move the addressed lane down to bit 0 and sign/zero extend it.
    function automatic logic [31:0] load_extend(input logic [1:0]  dsize,
                                                input logic        sext,
                                                input logic [1:0]  off,
                                                input logic [31:0] rdata);
        logic [31:0] shifted;
        logic [15:0] half;
        logic [7:0]  lane;
        logic [31:0] r;
        shifted = rdata >> {off, 3'b000};
        half    = off[1] ? rdata[31:16] : rdata[15:0];
        lane    = shifted[7:0];
        case (dsize)
            2'b01:   r = {{16{sext & half[15]}}, half};
            2'b10:   r = {{24{sext & lane[7]}}, lane};
            default: r = rdata;
        endcase
        return r;
    endfunction

    // DONE accepts like IDLE, so only ACCESS stalls upstream.
    assign in_ready = (state != ACCESS);
    assign accept   = in_valid && in_ready;
    assign is_mem   = MemWr_in | MemToReg_in;
    assign misal    = is_mem &&
                      (((Dsize_in == 2'b01) && alu_in[0]) ||
                       (((Dsize_in == 2'b00) || (Dsize_in == 2'b11)) &&
                        (alu_in[1:0] != 2'b00)));
    assign start    = accept && is_mem && !misal;
    // An ack outside ACCESS (mem_req low) is ignored.
    assign ack_hit  = (state == ACCESS) && mem_ack;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] to_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (start) begin
            to_cnt <= '0;
        end else if (state == ACCESS) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // An ack on the last permitted cycle takes priority over the abort.
    assign timeout = (state == ACCESS) && !mem_ack &&
                     (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = start ? ACCESS : IDLE;
            ACCESS: begin
                if (ack_hit) begin
                    state_nx = DONE;
                end else if (timeout) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // ---- stage p0: operation latch (no reset; only read in ACCESS) ----
    always_ff @(posedge clock) begin
        if (start) begin
            store_p0 <= MemWr_in;
            load_p0  <= MemToReg_in & ~MemWr_in;
            regwr_p0 <= RegWr_in;
            rd_p0    <= rd_in;
            alu_p0   <= alu_in;
            dsize_p0 <= Dsize_in;
            ext_p0   <= Loadext_in;
        end
    end

    // ---- stage p1: bus request and MEM/WB register ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_be      <= '0;
            mem_wdata   <= '0;
            wb_valid    <= 1'b0;
            wb_RegWr    <= 1'b0;
            wb_MemToReg <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            misalign    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            bus_err     <= 1'b0;
`endif
        end else begin
            wb_valid <= 1'b0;
            misalign <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            bus_err  <= 1'b0;
`endif
            if (accept) begin
                if (!is_mem) begin
                    wb_valid    <= 1'b1;
                    wb_RegWr    <= RegWr_in;
                    wb_MemToReg <= 1'b0;
                    wb_rd       <= rd_in;
                    wb_data     <= alu_in;
                end else if (misal) begin
                    // Dropped access still retires, but never writes a register.
                    misalign    <= 1'b1;
                    wb_valid    <= 1'b1;
                    wb_RegWr    <= 1'b0;
                    wb_MemToReg <= 1'b0;
                    wb_rd       <= rd_in;
                    wb_data     <= alu_in;
                end else begin
                    mem_req   <= 1'b1;
                    mem_we    <= MemWr_in;
                    mem_addr  <= {alu_in[31:2], 2'b00};
                    mem_be    <= lane_be(Dsize_in, alu_in[1:0]);
                    mem_wdata <= lane_wdata(Dsize_in, store_in);
                end
            end else if (ack_hit) begin
                mem_req     <= 1'b0;
                mem_we      <= 1'b0;
                wb_valid    <= 1'b1;
                wb_RegWr    <= regwr_p0 & ~store_p0;
                wb_MemToReg <= load_p0;
                wb_rd       <= rd_p0;
                wb_data     <= load_p0 ?
                               load_extend(dsize_p0, ext_p0, alu_p0[1:0], mem_rdata) :
                               alu_p0;
            end else if (timeout) begin
                mem_req     <= 1'b0;
                mem_we      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                bus_err     <= 1'b1;
`endif
                wb_valid    <= 1'b1;
                wb_RegWr    <= 1'b0;
                wb_MemToReg <= 1'b0;
                wb_rd       <= rd_p0;
                wb_data     <= alu_p0;
            end
        end
    end

endmodule

// File: doc/mem_unit.md
# mem_unit

Memory-access stage of the single-cycle/pipelined datapath. It consumes the EX/MEM pipeline register written by the execute stage: registered control bits, ALU result and store data. It runs a request/acknowledge transaction on the data-memory bus with byte-lane steering and load extension, then writes the MEM/WB pipeline register. It stalls upstream while a memory transaction is outstanding.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles `mem_req` may wait for `mem_ack`; used only with MEM_TIMEOUT_EN.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  EX/MEM register holds a valid instruction
- in_ready  output  1  stage accepts `in_*` this cycle
- MemWr_in  input  1  store
- MemToReg_in  input  1  load; result comes from memory
- RegWr_in  input  1  writeback enable
- Dsize_in  input  2  00 word, 01 half, 10 byte, 11 treated as word
- Loadext_in  input  1  1 sign-extend, 0 zero-extend sub-word loads
- rd_in  input  5  destination register
- alu_in  input  32  ALU result / effective address
- store_in  input  32  store data (BusB)
- mem_req  output  1  bus request
- mem_we  output  1  write strobe
- mem_addr  output  32  word-aligned address ({alu[31:2],2'b00})
- mem_be  output  4  byte enables
- mem_wdata  output  32  lane-steered store data
- mem_ack  input  1  transaction complete
- mem_rdata  input  32  read data, valid with `mem_ack`
- wb_valid  output  1  MEM/WB register valid
- wb_RegWr  output  1  registered RegWr
- wb_MemToReg  output  1  registered MemToReg
- wb_rd  output  5  registered destination
- wb_data  output  32  load data or pass-through ALU result
- misalign  output  1  one-cycle pulse: misaligned access dropped
- bus_err  output  1  one-cycle pulse: timeout abort

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid without MemWr/MemToReg: load MEM/WB with wb_data=alu_in; stay in IDLE.
  - On in_valid with a memory op: check alignment first.
    - Half with alu[0]=1, or word with alu[1:0]≠0: pulse misalign, write wb_valid=1 with wb_RegWr=0, no bus access.
    - Otherwise latch the operation and go to ACCESS.
- ACCESS:
  - mem_req=1; address, be, wdata and we are held stable; in_ready=0.
  - On mem_ack: capture the extended load data; go to DONE.
- DONE:
  - MEM/WB written; in_ready=1; behaves as IDLE in the same cycle, so back-to-back accepts are allowed.
- Byte enables:
  - Word 1111.
  - Half 0011 (alu[1]=0) or 1100 (alu[1]=1).
  - Byte 0001 shifted left by alu[1:0].
- Store data:
  - Half replicated {s[15:0],s[15:0]}.
  - Byte replicated 4× s[7:0].
- Load data: the selected lane is shifted to bits [7:0]/[15:0], then extended per Loadext.
- Stores: wb_RegWr=0 regardless of RegWr_in.
- wb_valid deasserts in any cycle that does not write MEM/WB.

## Timing
- Reset (async, reset=0): state IDLE; mem_req, mem_we, wb_valid, wb_RegWr, wb_MemToReg, misalign, bus_err = 0; mem_addr, mem_be, mem_wdata, wb_rd, wb_data = 0.
- Non-memory op accepted at edge T: wb_* valid after edge T.
- Memory op accepted at edge T:
  - mem_req high after T.
  - mem_ack sampled high at edge T+k (k≥1): mem_req low and wb_valid high after T+k.
  - Minimum latency 2 cycles.
- mem_ack while mem_req=0: ignored.
- A mem_ack arriving the same cycle as the request is raised cannot occur, because the request is registered.
- Reset asserted mid-ACCESS: transaction abandoned; mem_req drops immediately; any later ack is ignored.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A counter runs in ACCESS.
  - After TIMEOUT_CYCLES cycles without ack: drop mem_req, pulse bus_err, write wb_valid=1 with wb_RegWr=0, return to IDLE.
  - An ack on the final cycle wins over the timeout.
- MEM_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; bus_err tied 0.

## Test plan
- R-type pass-through: alu_in=0x0000_1234, RegWr_in=1, rd=5 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=5, mem_req never high.
- Byte store: alu_in=0x103, store_in=0xAB, Dsize=10 -> mem_be=1000, mem_wdata=0xABABABAB, mem_addr=0x100, mem_we=1; ack after 3 cycles -> wb_RegWr=0, in_ready low for those cycles.
- Signed half load: alu_in=0x202, rdata=0x8001_0000, Loadext=1 -> wb_data=0xFFFF8001; with Loadext=0 -> 0x00008001.
- Misaligned word: alu_in=0x101, MemToReg=1 -> misalign pulse, mem_req stays 0, wb_RegWr=0.
- Reset mid-ACCESS: reset low while mem_req=1 -> all outputs 0 asynchronously; ack after release ignored, state IDLE.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> mem_req high exactly 4 cycles, bus_err pulse, wb_valid=1 with wb_RegWr=0.
